// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI target controller.
package pci_pkg;

    localparam int unsigned PCI_AD_W  = 32;
    localparam int unsigned PCI_CBE_W = 4;

    localparam logic [PCI_CBE_W-1:0] CMD_MEM_RD = 4'b0110;
    localparam logic [PCI_CBE_W-1:0] CMD_MEM_WR = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLAIM = 3'd1,
        S_XFER  = 3'd2,
        S_DISC  = 3'd3,
        S_TURN  = 3'd4,
        S_BUSY  = 3'd5
    } pci_state_e;

    // Bus-side control outputs, decoded purely from state.
    typedef struct packed {
        logic devsel_n;
        logic trdy_n;
        logic stop_n;
        logic ad_oe;
    } pci_bus_ctl_t;

    // True for the two memory commands this target can claim.
    function automatic logic is_mem_cmd(input logic [PCI_CBE_W-1:0] cmd);
        return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
    endfunction

endpackage

// File: rtl/pci_burst_addr.sv
// Burst word-address counter: load on address phase, step per transfer.
module pci_burst_addr #(
    parameter int unsigned addr_w = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic [addr_w-1:0] i_load_val,
    output logic [addr_w-1:0] o_addr,
    output logic              o_last_c
);

    localparam logic [addr_w-1:0] LAST_WORD = {addr_w{1'b1}};

    logic [addr_w-1:0] r_addr;

    // Address register; increment wraps naturally at depth-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_inc) begin
            r_addr <= r_addr + addr_w'(1);
        end
    end

    assign o_addr   = r_addr;
    assign o_last_c = (r_addr == LAST_WORD);

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI target controller sequencing a small on-chip data memory.
module pci_target_ctrl
    import pci_pkg::*;
#(
    parameter int unsigned addr_w = 4,
    parameter logic [27:0] BASE   = 28'h0000_001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FRAME_n,
    input  logic                 IRDY_n,
    input  logic [PCI_AD_W-1:0]  AD_in,
    input  logic [PCI_CBE_W-1:0] CBE_n,
    output logic [PCI_AD_W-1:0]  AD_out,
    output logic                 AD_oe,
    output logic                 DEVSEL_n,
    output logic                 TRDY_n,
    output logic                 STOP_n,
    output logic [addr_w-1:0]    ADDR_M,
    output logic                 Mem_WE,
    output logic [PCI_AD_W-1:0]  IN_DATA_M,
    output logic [PCI_CBE_W-1:0] BE,
    input  logic [PCI_AD_W-1:0]  OUT_DATA_M
);

    localparam int unsigned TAG_W = PCI_AD_W - addr_w - 2;

    pci_state_e           r_state;
    pci_state_e           w_next_state;
    logic [PCI_CBE_W-1:0] r_cmd;
    logic                 r_frame_prev;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_addr_phase;
    logic                 w_hit;
    logic                 w_is_rd;
    logic                 w_is_wr;
    logic                 w_addr_load;
    logic                 w_addr_inc;
    logic                 w_addr_clr;
    logic [addr_w-1:0]    w_addr;
    logic                 w_last;
    pci_bus_ctl_t         w_ctl;

    assign w_tag        = AD_in[PCI_AD_W-1:addr_w+2];
    assign w_addr_phase = r_frame_prev && !FRAME_n;
    assign w_hit        = is_mem_cmd(CBE_n) && (w_tag == BASE[TAG_W-1:0]);
    assign w_is_rd      = (r_cmd == CMD_MEM_RD);
    assign w_is_wr      = (r_cmd == CMD_MEM_WR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Previous FRAME# for address-phase edge detection; command latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_prev <= 1'b1;
            r_cmd        <= '0;
        end else begin
            r_frame_prev <= FRAME_n;
            if (w_addr_load) begin
                r_cmd <= CBE_n;
            end
        end
    end

    // Next-state, counter control and bus control decode (from state only).
    always_comb begin
        w_next_state   = r_state;
        w_addr_load    = 1'b0;
        w_addr_inc     = 1'b0;
        w_addr_clr     = 1'b0;
        w_ctl.devsel_n = 1'b1;
        w_ctl.trdy_n   = 1'b1;
        w_ctl.stop_n   = 1'b1;
        w_ctl.ad_oe    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_addr_phase) begin
                    w_addr_load  = 1'b1;
                    w_next_state = w_hit ? S_CLAIM : S_BUSY;
                end
            end
            S_CLAIM: begin
                w_ctl.devsel_n = 1'b0;
                w_next_state   = S_XFER;
            end
            S_XFER: begin
                w_ctl.devsel_n = 1'b0;
                w_ctl.trdy_n   = 1'b0;
                w_ctl.ad_oe    = w_is_rd;
                if (!IRDY_n) begin
                    if (FRAME_n) begin
                        w_next_state = S_TURN;
                    end else begin
                        w_addr_inc = 1'b1;
                        if (w_last) begin
                            w_next_state = S_DISC;
                        end
                    end
                end
            end
            S_DISC: begin
                w_ctl.devsel_n = 1'b0;
                w_ctl.stop_n   = 1'b0;
                w_ctl.ad_oe    = w_is_rd;
                if (FRAME_n) begin
                    w_next_state = S_TURN;
                end
            end
            S_TURN: begin
                w_addr_clr   = 1'b1;
                w_next_state = S_IDLE;
            end
            S_BUSY: begin
                if (FRAME_n && IRDY_n) begin
                    w_addr_clr   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_addr_clr   = 1'b1;
                w_next_state = S_IDLE;
            end
        endcase
    end

    pci_burst_addr #(
        .addr_w (addr_w)
    ) u_burst_addr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_addr_load),
        .i_inc      (w_addr_inc),
        .i_clr      (w_addr_clr),
        .i_load_val (AD_in[addr_w+1:2]),
        .o_addr     (w_addr),
        .o_last_c   (w_last)
    );

    assign DEVSEL_n  = w_ctl.devsel_n;
    assign TRDY_n    = w_ctl.trdy_n;
    assign STOP_n    = w_ctl.stop_n;
    assign AD_oe     = w_ctl.ad_oe;
    assign AD_out    = OUT_DATA_M;
    assign ADDR_M    = w_addr;
    assign IN_DATA_M = AD_in;
    assign BE        = CBE_n;
    // Write strobe is gated by reset so an aborted burst cannot commit a word.
    assign Mem_WE    = !rst && (r_state == S_XFER) && w_is_wr && !IRDY_n;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Self-checking bench for pci_target_ctrl with a behavioural 16-word memory.
module tb_pci_target_ctrl;
    import pci_pkg::*;

    localparam int unsigned AW = 4;
    // BASE=1 places the target window at AD[31:6]==1, i.e. byte address 0x40.
    localparam logic [31:0] WIN = 32'h0000_0040;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wr_exp_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          FRAME_n;
    logic          IRDY_n;
    logic [31:0]   AD_in;
    logic [3:0]    CBE_n;
    logic [31:0]   AD_out;
    logic          AD_oe;
    logic          DEVSEL_n;
    logic          TRDY_n;
    logic          STOP_n;
    logic [AW-1:0] ADDR_M;
    logic          Mem_WE;
    logic [31:0]   IN_DATA_M;
    logic [3:0]    BE;
    logic [31:0]   OUT_DATA_M;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    bit          mem_init_done = 1'b0;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    pci_target_ctrl #(
        .addr_w (AW),
        .BASE   (28'h0000_001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .FRAME_n    (FRAME_n),
        .IRDY_n     (IRDY_n),
        .AD_in      (AD_in),
        .CBE_n      (CBE_n),
        .AD_out     (AD_out),
        .AD_oe      (AD_oe),
        .DEVSEL_n   (DEVSEL_n),
        .TRDY_n     (TRDY_n),
        .STOP_n     (STOP_n),
        .ADDR_M     (ADDR_M),
        .Mem_WE     (Mem_WE),
        .IN_DATA_M  (IN_DATA_M),
        .BE         (BE),
        .OUT_DATA_M (OUT_DATA_M)
    );

    // Memory: combinational read, falling-edge byte-masked write.
    assign OUT_DATA_M = mem[ADDR_M];
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            mem_init_done <= 1'b1;
        end else if (Mem_WE === 1'b1) begin
            for (int b = 0; b < 4; b++)
                if (!BE[b]) mem[ADDR_M][8*b +: 8] <= IN_DATA_M[8*b +: 8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard monitors at the falling edge, return 1ns after rise.
    task automatic tick();
        wr_exp_t we;
        rd_exp_t re;
        @(negedge clk);
        if (Mem_WE === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL mem_write: unexpected write addr=%0d data=%h be=%b", ADDR_M, IN_DATA_M, BE);
            end else begin
                we = wr_q.pop_front();
                if ({ADDR_M, IN_DATA_M, BE} !== {we.a, we.d, we.be}) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0d data=%h be=%b, want addr=%0d data=%h be=%b",
                             ADDR_M, IN_DATA_M, BE, we.a, we.d, we.be);
                end
            end
        end
        if (TRDY_n === 1'b0 && IRDY_n === 1'b0 && AD_oe === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_data: unexpected read addr=%0d data=%h", ADDR_M, AD_out);
            end else begin
                re = rd_q.pop_front();
                if ({ADDR_M, AD_out} !== {re.a, re.d}) begin
                    errors++;
                    $display("FAIL read_data: got addr=%0d data=%h, want addr=%0d data=%h",
                             ADDR_M, AD_out, re.a, re.d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic frame_n, input logic irdy_n, input logic [31:0] ad, input logic [3:0] cbe);
        FRAME_n = frame_n;
        IRDY_n  = irdy_n;
        AD_in   = ad;
        CBE_n   = cbe;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        drive(1'b0, 1'b1, a, cmd);
        tick();
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_q.push_back('{a: a, d: d, be: be});
        for (int b = 0; b < 4; b++)
            if (!be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        rd_q.push_back('{a: a, d: ref_mem[a]});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        tick();
        checks++;
        if ({DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE} !== 5'b11100 || ADDR_M !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dev/trdy/stop/oe/we=%b addr=%0d, want 11100 addr=0",
                     {DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE}, ADDR_M);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE} !== 5'b11100 || ADDR_M !== 4'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %b addr=%0d, want 11100 addr=0",
                     {DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE}, ADDR_M);
        end
    endtask

    task automatic test_single_write();
        addr_phase(WIN | 32'h10, CMD_MEM_WR);
        checks++;
        if ({DEVSEL_n, TRDY_n} !== 2'b01) begin
            errors++;
            $display("FAIL sw_claim: got devsel/trdy=%b, want 01", {DEVSEL_n, TRDY_n});
        end
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 4'h0);
        push_wr(4'd4, 32'hDEAD_BEEF, 4'h0);
        #1;
        checks++;
        if (Mem_WE !== 1'b0) begin
            errors++;
            $display("FAIL sw_we_in_claim: got Mem_WE=%b, want 0", Mem_WE);
        end
        tick();
        checks++;
        if ({TRDY_n, Mem_WE} !== 2'b01 || ADDR_M !== 4'd4) begin
            errors++;
            $display("FAIL sw_xfer: got trdy/we=%b addr=%0d, want 01 addr=4", {TRDY_n, Mem_WE}, ADDR_M);
        end
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        checks++;
        if ({DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE} !== 5'b11100) begin
            errors++;
            $display("FAIL sw_turn: got %b, want 11100", {DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE});
        end
        tick();
        checks++;
        if (ADDR_M !== 4'd0 || DEVSEL_n !== 1'b1 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL sw_idle: got addr=%0d devsel=%b pending=%0d, want 0 1 0", ADDR_M, DEVSEL_n, wr_q.size());
        end
    endtask

    task automatic test_burst_read();
        addr_phase(WIN | 32'h08, CMD_MEM_RD);
        checks++;
        if ({DEVSEL_n, TRDY_n, AD_oe} !== 3'b010) begin
            errors++;
            $display("FAIL rd_claim: got devsel/trdy/oe=%b, want 010", {DEVSEL_n, TRDY_n, AD_oe});
        end
        for (int i = 0; i < 4; i++) push_rd(4'(2 + i));
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({TRDY_n, AD_oe} !== 2'b01 || ADDR_M !== 4'(2 + i)) begin
                errors++;
                $display("FAIL rd_beat%0d: got trdy/oe=%b addr=%0d, want 01 addr=%0d", i, {TRDY_n, AD_oe}, ADDR_M, 2 + i);
            end
            if (i == 3) FRAME_n = 1'b1;
        end
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        checks++;
        if ({DEVSEL_n, TRDY_n, AD_oe} !== 3'b110) begin
            errors++;
            $display("FAIL rd_turn: got devsel/trdy/oe=%b, want 110", {DEVSEL_n, TRDY_n, AD_oe});
        end
        tick();
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_count: got %0d reads outstanding, want 0", rd_q.size());
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] d;
        addr_phase(WIN | 32'h20, CMD_MEM_WR);
        drive(1'b0, 1'b1, 32'h0, 4'hF);
        tick();
        checks++;
        if ({TRDY_n, Mem_WE} !== 2'b00) begin
            errors++;
            $display("FAIL ws_first_wait: got trdy/we=%b, want 00", {TRDY_n, Mem_WE});
        end
        for (int k = 0; k < 3; k++) begin
            d = 32'hC0DE_0000 + 32'(k);
            drive(k == 2, 1'b0, d, 4'h0);
            push_wr(4'(8 + k), d, 4'h0);
            #1;
            checks++;
            if (Mem_WE !== 1'b1 || ADDR_M !== 4'(8 + k)) begin
                errors++;
                $display("FAIL ws_beat%0d: got we=%b addr=%0d, want 1 addr=%0d", k, Mem_WE, ADDR_M, 8 + k);
            end
            tick();
            if (k < 2) begin
                for (int w = 0; w < 2; w++) begin
                    drive(1'b0, 1'b1, 32'hBAD0_0000, 4'h0);
                    #1;
                    checks++;
                    if (Mem_WE !== 1'b0 || TRDY_n !== 1'b0 || ADDR_M !== 4'(9 + k)) begin
                        errors++;
                        $display("FAIL ws_wait: got we=%b trdy=%b addr=%0d, want 0 0 addr=%0d", Mem_WE, TRDY_n, ADDR_M, 9 + k);
                    end
                    tick();
                end
            end
        end
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        for (int a = 7; a <= 11; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++;
                $display("FAIL ws_mem%0d: got %h, want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_miss();
        addr_phase(32'h0000_0100, CMD_MEM_WR);
        for (int c = 0; c < 4; c++) begin
            drive(c == 3, 1'b0, 32'h5555_AAAA, 4'h0);
            #1;
            checks++;
            if ({DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE} !== 5'b11100) begin
                errors++;
                $display("FAIL miss_busy%0d: got %b, want 11100", c, {DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE});
            end
            tick();
        end
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        checks++;
        if (ADDR_M !== 4'd0 || DEVSEL_n !== 1'b1) begin
            errors++;
            $display("FAIL miss_idle: got addr=%0d devsel=%b, want 0 1", ADDR_M, DEVSEL_n);
        end
    endtask

    task automatic test_wrap_disconnect();
        addr_phase(WIN | 32'h38, CMD_MEM_WR);
        checks++;
        if (DEVSEL_n !== 1'b0) begin
            errors++;
            $display("FAIL wrap_claim: got devsel=%b, want 0", DEVSEL_n);
        end
        drive(1'b0, 1'b1, 32'h0, 4'hF);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 32'h1234_5600 + 32'(k), 4'h0);
            push_wr(4'(14 + k), 32'h1234_5600 + 32'(k), 4'h0);
            tick();
        end
        drive(1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({DEVSEL_n, TRDY_n, STOP_n, Mem_WE} !== 4'b0100) begin
                errors++;
                $display("FAIL wrap_disc%0d: got devsel/trdy/stop/we=%b, want 0100", c, {DEVSEL_n, TRDY_n, STOP_n, Mem_WE});
            end
            tick();
        end
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0);
        tick();
        checks++;
        if ({DEVSEL_n, TRDY_n, STOP_n} !== 3'b111) begin
            errors++;
            $display("FAIL wrap_turn: got devsel/trdy/stop=%b, want 111", {DEVSEL_n, TRDY_n, STOP_n});
        end
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        checks++;
        if (mem[0] !== ref_mem[0] || mem[14] !== ref_mem[14] || mem[15] !== ref_mem[15] || wr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_mem: got m0=%h m14=%h m15=%h pending=%0d, want %h %h %h 0",
                     mem[0], mem[14], mem[15], wr_q.size(), ref_mem[0], ref_mem[14], ref_mem[15]);
        end
    endtask

    task automatic test_reset_midburst();
        addr_phase(WIN | 32'h18, CMD_MEM_WR);
        drive(1'b0, 1'b1, 32'h0, 4'hF);
        tick();
        drive(1'b0, 1'b0, 32'hAAAA_0006, 4'h0);
        push_wr(4'd6, 32'hAAAA_0006, 4'h0);
        tick();
        drive(1'b0, 1'b0, 32'hAAAA_0007, 4'h0);
        rst = 1'b1;
        #1;
        checks++;
        if (Mem_WE !== 1'b0) begin
            errors++;
            $display("FAIL rst_we_gate: got Mem_WE=%b, want 0", Mem_WE);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'hAAAA_0008, 4'h0);
        #1;
        checks++;
        if ({DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE} !== 5'b11100 || ADDR_M !== 4'd0) begin
            errors++;
            $display("FAIL rst_outputs: got %b addr=%0d, want 11100 addr=0",
                     {DEVSEL_n, TRDY_n, STOP_n, AD_oe, Mem_WE}, ADDR_M);
        end
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        checks++;
        if (mem[6] !== ref_mem[6] || mem[7] !== ref_mem[7]) begin
            errors++;
            $display("FAIL rst_mem: got m6=%h m7=%h, want %h %h", mem[6], mem[7], ref_mem[6], ref_mem[7]);
        end
    endtask

    task automatic test_back_to_back();
        addr_phase(WIN | 32'h04, CMD_MEM_WR);
        checks++;
        if ({DEVSEL_n, TRDY_n} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_claim: got devsel/trdy=%b, want 01", {DEVSEL_n, TRDY_n});
        end
        drive(1'b1, 1'b0, 32'h0BAD_F00D, 4'b1100);
        push_wr(4'd1, 32'h0BAD_F00D, 4'b1100);
        tick();
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        addr_phase(WIN | 32'h04, CMD_MEM_RD);
        push_rd(4'd1);
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        checks++;
        if ({TRDY_n, AD_oe} !== 2'b01 || ADDR_M !== 4'd1) begin
            errors++;
            $display("FAIL b2b_read: got trdy/oe=%b addr=%0d, want 01 addr=1", {TRDY_n, AD_oe}, ADDR_M);
        end
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'hF);
        tick();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got wr=%0d rd=%0d outstanding, want 0 0", wr_q.size(), rd_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        test_reset();
        test_single_write();
        test_burst_read();
        test_wait_states();
        test_miss();
        test_wrap_disconnect();
        test_reset_midburst();
        test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL final_mem%0d: got %h, want %h", i, mem[i], ref_mem[i]);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
